// File: rtl/apb_bridge_nslv.sv
// apb_bridge_nslv: registered APB fabric bridge.
// One upstream APB slave port fans out to NUM_SLAVES downstream APB master ports,
// selected by address window. Unmapped addresses get an error response, stalled
// downstream accesses are aborted after TIMEOUT_CYCLES, and error responses are
// counted in a saturating counter.
//
// Ports:
//   pclk, preset          clock, synchronous active-high reset
//   s_*                   upstream APB slave port (paddr/psel/penable/pwrite/pwdata in,
//                         prdata/pready/pslverr out)
//   m_*                   downstream APB master ports; paddr/pwdata/pwrite/penable are
//                         broadcast, psel is one-hot, prdata/pready/pslverr per slave
//                         (slave i read data at m_prdata[i*W +: W])
//   err_count             saturating count of error responses
//   timeout_pulse         one-cycle pulse when a downstream access is aborted
module apb_bridge_nslv #(
  parameter int unsigned                 APB_ADDR_WIDTH = 32,
  parameter int unsigned                 APB_DATA_WIDTH = 32,
  parameter int unsigned                 NUM_SLAVES     = 4,
  parameter int unsigned                 SLV_WIN_BITS   = 12,
  parameter logic [APB_ADDR_WIDTH-1:0]   BASE_ADDR      = 32'h4000_0000,
  parameter int unsigned                 TIMEOUT_CYCLES = 16
) (
  input  logic                                 pclk,
  input  logic                                 preset,
  input  logic [APB_ADDR_WIDTH-1:0]            s_paddr,
  input  logic                                 s_psel,
  input  logic                                 s_penable,
  input  logic                                 s_pwrite,
  input  logic [APB_DATA_WIDTH-1:0]            s_pwdata,
  output logic [APB_DATA_WIDTH-1:0]            s_prdata,
  output logic                                 s_pready,
  output logic                                 s_pslverr,
  output logic [APB_ADDR_WIDTH-1:0]            m_paddr,
  output logic [APB_DATA_WIDTH-1:0]            m_pwdata,
  output logic                                 m_pwrite,
  output logic                                 m_penable,
  output logic [NUM_SLAVES-1:0]                m_psel,
  input  logic [NUM_SLAVES*APB_DATA_WIDTH-1:0] m_prdata,
  input  logic [NUM_SLAVES-1:0]                m_pready,
  input  logic [NUM_SLAVES-1:0]                m_pslverr,
  output logic [15:0]                          err_count,
  output logic                                 timeout_pulse
);

  localparam int unsigned IDX_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
  // Timer only needs to reach TIMEOUT_CYCLES-1.
  localparam int unsigned TMR_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TMR_W-1:0] TMR_LAST =
      TMR_W'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {StIdle, StDecErr, StMSetup, StMAccess, StResp} state_e;

  state_e                    r_state, w_state_d;
  logic [APB_ADDR_WIDTH-1:0] r_addr;
  logic [APB_DATA_WIDTH-1:0] r_wdata;
  logic                      r_write;
  logic [IDX_W-1:0]          r_idx;
  logic [TMR_W-1:0]          r_timer, w_timer_d;
  logic [APB_DATA_WIDTH-1:0] r_rsp_data, w_rsp_data_d;
  logic                      r_rsp_err, w_rsp_err_d;
  logic [15:0]               r_err_count;
  logic                      r_timeout, w_timeout_d;

  logic [APB_ADDR_WIDTH-1:0] w_off;
  logic [APB_ADDR_WIDTH-1:0] w_win;
  logic                      w_mapped;
  logic                      w_capture;
  logic                      w_err_inc;
  logic [APB_DATA_WIDTH-1:0] w_sel_rdata;

  // Address decode on the live upstream address; only used at capture time.
  assign w_off    = s_paddr - BASE_ADDR;
  assign w_win    = w_off >> SLV_WIN_BITS;
  assign w_mapped = (s_paddr >= BASE_ADDR) && (w_win < APB_ADDR_WIDTH'(NUM_SLAVES));

  assign w_sel_rdata = m_prdata[int'(r_idx)*APB_DATA_WIDTH +: APB_DATA_WIDTH];

  always_comb begin
    w_state_d    = r_state;
    w_timer_d    = r_timer;
    w_rsp_data_d = r_rsp_data;
    w_rsp_err_d  = r_rsp_err;
    w_timeout_d  = 1'b0;
    w_capture    = 1'b0;
    case (r_state)
      StIdle: begin
        if (s_psel && !s_penable) begin
          w_capture = 1'b1;
          w_state_d = w_mapped ? StMSetup : StDecErr;
        end
      end
      StDecErr: begin
        w_rsp_data_d = '0;
        w_rsp_err_d  = 1'b1;
        w_state_d    = StResp;
      end
      StMSetup: begin
        w_timer_d = '0;
        w_state_d = StMAccess;
      end
      StMAccess: begin
        w_timer_d = r_timer + 1'b1;
        // pready wins over a timeout in the same cycle.
        if (m_pready[r_idx]) begin
          w_rsp_data_d = r_write ? '0 : w_sel_rdata;
          w_rsp_err_d  = m_pslverr[r_idx];
          w_state_d    = StResp;
        end else if ((TIMEOUT_CYCLES != 0) && (r_timer == TMR_LAST)) begin
          w_rsp_data_d = '0;
          w_rsp_err_d  = 1'b1;
          w_timeout_d  = 1'b1;
          w_state_d    = StResp;
        end
      end
      StResp: begin
        // Return to idle regardless of upstream psel so a misbehaving master cannot hang us.
        w_state_d = StIdle;
      end
      default: w_state_d = StIdle;
    endcase
  end

  assign w_err_inc = (w_state_d == StResp) && (r_state != StResp) && w_rsp_err_d;

  always_ff @(posedge pclk) begin
    if (preset) begin
      r_state     <= StIdle;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_write     <= 1'b0;
      r_idx       <= '0;
      r_timer     <= '0;
      r_rsp_data  <= '0;
      r_rsp_err   <= 1'b0;
      r_err_count <= '0;
      r_timeout   <= 1'b0;
    end else begin
      r_state    <= w_state_d;
      r_timer    <= w_timer_d;
      r_rsp_data <= w_rsp_data_d;
      r_rsp_err  <= w_rsp_err_d;
      r_timeout  <= w_timeout_d;
      if (w_capture) begin
        r_addr  <= s_paddr;
        r_wdata <= s_pwdata;
        r_write <= s_pwrite;
        r_idx   <= w_win[IDX_W-1:0];
      end
      if (w_err_inc && (r_err_count != 16'hFFFF)) begin
        r_err_count <= r_err_count + 16'd1;
      end
    end
  end

  // All downstream outputs derive from captured registers and state only.
  always_comb begin
    m_psel = '0;
    if ((r_state == StMSetup) || (r_state == StMAccess)) begin
      m_psel[r_idx] = 1'b1;
    end
  end

  assign m_penable     = (r_state == StMAccess);
  assign m_paddr       = r_addr;
  assign m_pwdata      = r_wdata;
  assign m_pwrite      = r_write;
  assign s_pready      = (r_state == StResp);
  assign s_prdata      = (r_state == StResp) ? r_rsp_data : '0;
  assign s_pslverr     = (r_state == StResp) ? r_rsp_err : 1'b0;
  assign err_count     = r_err_count;
  assign timeout_pulse = r_timeout;

endmodule

// File: tb/tb_apb_bridge_nslv.sv
module tb_apb_bridge_nslv;

  logic         pclk = 1'b0;
  logic         preset;
  logic [31:0]  s_paddr;
  logic         s_psel, s_penable, s_pwrite;
  logic [31:0]  s_pwdata;
  logic [31:0]  s_prdata;
  logic         s_pready, s_pslverr;
  logic [31:0]  m_paddr, m_pwdata;
  logic         m_pwrite, m_penable;
  logic [3:0]   m_psel;
  logic [127:0] m_prdata;
  logic [3:0]   m_pready, m_pslverr;
  logic [15:0]  err_count;
  logic         timeout_pulse;

  int n_tests = 0;
  int n_fail  = 0;

  apb_bridge_nslv dut (
    .pclk          (pclk),
    .preset        (preset),
    .s_paddr       (s_paddr),
    .s_psel        (s_psel),
    .s_penable     (s_penable),
    .s_pwrite      (s_pwrite),
    .s_pwdata      (s_pwdata),
    .s_prdata      (s_prdata),
    .s_pready      (s_pready),
    .s_pslverr     (s_pslverr),
    .m_paddr       (m_paddr),
    .m_pwdata      (m_pwdata),
    .m_pwrite      (m_pwrite),
    .m_penable     (m_penable),
    .m_psel        (m_psel),
    .m_prdata      (m_prdata),
    .m_pready      (m_pready),
    .m_pslverr     (m_pslverr),
    .err_count     (err_count),
    .timeout_pulse (timeout_pulse)
  );

  always #5 pclk = ~pclk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach the end of the sequence");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  // Drive an APB setup phase; returns in cycle T1 with penable raised.
  task automatic start(input logic [31:0] addr, input logic wr, input logic [31:0] wdata);
    s_paddr   = addr;
    s_pwrite  = wr;
    s_pwdata  = wdata;
    s_psel    = 1'b1;
    s_penable = 1'b0;
    tick();
    s_penable = 1'b1;
  endtask

  task automatic finish_xfer();
    s_psel    = 1'b0;
    s_penable = 1'b0;
  endtask

  initial begin
    preset    = 1'b1;
    s_paddr   = '0;
    s_psel    = 1'b0;
    s_penable = 1'b0;
    s_pwrite  = 1'b0;
    s_pwdata  = '0;
    m_prdata  = {32'hDEAD_BEEF, 32'h0000_0000, 32'hCAFE_0001, 32'h5A5A_0000};
    m_pready  = '0;
    m_pslverr = '0;
    tick();
    tick();
    preset = 1'b0;

    chk("rst_pready",  {31'd0, s_pready}, 32'd0);
    chk("rst_psel",    {28'd0, m_psel}, 32'd0);
    chk("rst_penable", {31'd0, m_penable}, 32'd0);
    chk("rst_paddr",   m_paddr, 32'd0);
    chk("rst_errcnt",  {16'd0, err_count}, 32'd0);

    // Read slave 1, zero wait.
    m_pready = 4'b0010;
    start(32'h4000_1004, 1'b0, 32'd0);
    chk("rd_t1_psel",    {28'd0, m_psel}, 32'h2);
    chk("rd_t1_penable", {31'd0, m_penable}, 32'd0);
    chk("rd_t1_paddr",   m_paddr, 32'h4000_1004);
    tick();
    chk("rd_t2_penable", {31'd0, m_penable}, 32'd1);
    chk("rd_t2_pready",  {31'd0, s_pready}, 32'd0);
    tick();
    chk("rd_t3_pready",  {31'd0, s_pready}, 32'd1);
    chk("rd_t3_prdata",  s_prdata, 32'hCAFE_0001);
    chk("rd_t3_pslverr", {31'd0, s_pslverr}, 32'd0);
    chk("rd_t3_psel",    {28'd0, m_psel}, 32'd0);
    finish_xfer();
    tick();
    chk("rd_t4_pready",  {31'd0, s_pready}, 32'd0);
    chk("rd_t4_prdata",  s_prdata, 32'd0);

    // Write slave 3 with three wait states.
    m_pready = 4'b0000;
    start(32'h4000_3000, 1'b1, 32'h1234_5678);
    chk("wr_t1_psel",   {28'd0, m_psel}, 32'h8);
    chk("wr_t1_pwdata", m_pwdata, 32'h1234_5678);
    chk("wr_t1_pwrite", {31'd0, m_pwrite}, 32'd1);
    tick();
    tick();
    tick();
    chk("wr_t4_pready",  {31'd0, s_pready}, 32'd0);
    chk("wr_t4_penable", {31'd0, m_penable}, 32'd1);
    tick();
    m_pready = 4'b1000;
    tick();
    chk("wr_t6_pready",  {31'd0, s_pready}, 32'd1);
    chk("wr_t6_prdata",  s_prdata, 32'd0);
    chk("wr_t6_pslverr", {31'd0, s_pslverr}, 32'd0);
    finish_xfer();
    m_pready = 4'b0000;
    tick();

    // Decode error above the last window.
    start(32'h4000_4000, 1'b0, 32'd0);
    chk("de1_t1_psel",   {28'd0, m_psel}, 32'd0);
    chk("de1_t1_pready", {31'd0, s_pready}, 32'd0);
    tick();
    chk("de1_t2_pready",  {31'd0, s_pready}, 32'd1);
    chk("de1_t2_pslverr", {31'd0, s_pslverr}, 32'd1);
    chk("de1_t2_prdata",  s_prdata, 32'd0);
    finish_xfer();
    tick();

    // Decode error below base; master drops psel early.
    start(32'h3FFF_FFFC, 1'b0, 32'd0);
    finish_xfer();
    chk("de2_t1_psel", {28'd0, m_psel}, 32'd0);
    tick();
    chk("de2_t2_pready",  {31'd0, s_pready}, 32'd1);
    chk("de2_t2_pslverr", {31'd0, s_pslverr}, 32'd1);
    tick();
    chk("de2_t3_pready", {31'd0, s_pready}, 32'd0);
    chk("de2_errcnt",    {16'd0, err_count}, 32'd2);

    preset = 1'b1;
    tick();
    preset = 1'b0;
    chk("rst2_errcnt", {16'd0, err_count}, 32'd0);

    // Timeout on slave 2.
    start(32'h4000_2000, 1'b0, 32'd0);
    for (int k = 2; k <= 17; k++) tick();
    chk("to_t17_psel",    {28'd0, m_psel}, 32'h4);
    chk("to_t17_penable", {31'd0, m_penable}, 32'd1);
    chk("to_t17_pready",  {31'd0, s_pready}, 32'd0);
    chk("to_t17_pulse",   {31'd0, timeout_pulse}, 32'd0);
    tick();
    chk("to_t18_pready",  {31'd0, s_pready}, 32'd1);
    chk("to_t18_pslverr", {31'd0, s_pslverr}, 32'd1);
    chk("to_t18_prdata",  s_prdata, 32'd0);
    chk("to_t18_pulse",   {31'd0, timeout_pulse}, 32'd1);
    chk("to_t18_psel",    {28'd0, m_psel}, 32'd0);
    chk("to_t18_penable", {31'd0, m_penable}, 32'd0);
    chk("to_t18_errcnt",  {16'd0, err_count}, 32'd1);
    finish_xfer();
    tick();
    chk("to_t19_pulse",  {31'd0, timeout_pulse}, 32'd0);
    chk("to_t19_pready", {31'd0, s_pready}, 32'd0);

    // Slave 0 answers with pslverr on the last timeout cycle: pready wins.
    start(32'h4000_0010, 1'b0, 32'd0);
    for (int k = 2; k <= 17; k++) tick();
    m_pready  = 4'b0001;
    m_pslverr = 4'b0001;
    tick();
    chk("pw_pready",  {31'd0, s_pready}, 32'd1);
    chk("pw_prdata",  s_prdata, 32'h5A5A_0000);
    chk("pw_pslverr", {31'd0, s_pslverr}, 32'd1);
    chk("pw_pulse",   {31'd0, timeout_pulse}, 32'd0);
    chk("pw_errcnt",  {16'd0, err_count}, 32'd2);
    finish_xfer();
    m_pready  = 4'b0000;
    m_pslverr = 4'b0000;
    tick();

    // Reset during M_ACCESS.
    start(32'h4000_0000, 1'b0, 32'd0);
    tick();
    tick();
    chk("mr_t3_penable", {31'd0, m_penable}, 32'd1);
    preset = 1'b1;
    tick();
    chk("mr_psel",    {28'd0, m_psel}, 32'd0);
    chk("mr_penable", {31'd0, m_penable}, 32'd0);
    chk("mr_pready",  {31'd0, s_pready}, 32'd0);
    chk("mr_paddr",   m_paddr, 32'd0);
    chk("mr_errcnt",  {16'd0, err_count}, 32'd0);
    preset = 1'b0;
    finish_xfer();
    tick();

    // Read slave 0 after the reset.
    m_pready = 4'b0001;
    start(32'h4000_0000, 1'b0, 32'd0);
    chk("ar_t1_psel", {28'd0, m_psel}, 32'h1);
    tick();
    tick();
    chk("ar_t3_pready",  {31'd0, s_pready}, 32'd1);
    chk("ar_t3_prdata",  s_prdata, 32'h5A5A_0000);
    chk("ar_t3_pslverr", {31'd0, s_pslverr}, 32'd0);
    chk("ar_errcnt",     {16'd0, err_count}, 32'd0);
    finish_xfer();
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
